// File: rtl/vga_pattern_gen_if.sv
// Video-side bundle of the pattern generator: pixel enable and mode select in,
// registered sync/blank/colour/position out.
interface vga_pattern_gen_if #(
  parameter int HW         = 10,
  parameter int VW         = 10,
  parameter int COLOR_BITS = 8
);
  logic                  en;
  logic [1:0]            mode;
  logic                  hsync;
  logic                  vsync;
  logic                  hblank;
  logic                  vblank;
  logic [COLOR_BITS-1:0] r;
  logic [COLOR_BITS-1:0] g;
  logic [COLOR_BITS-1:0] b;
  logic [7:0]            frame;
  logic [HW-1:0]         hpos;
  logic [VW-1:0]         vpos;

  modport master (
    input  en, mode,
    output hsync, vsync, hblank, vblank, r, g, b, frame, hpos, vpos
  );

  modport slave (
    output en, mode,
    input  hsync, vsync, hblank, vblank, r, g, b, frame, hpos, vpos
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing plus four test patterns. Every output is registered
// from the counter state one enabled cycle earlier; pattern select latches per frame.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_BITS = 8,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_pattern_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // One spare bit so a sync region ending exactly at the total still compares.
  localparam logic [HW:0]   H_ACT_E = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   H_SS_E  = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   H_SE_E  = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT_E = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   V_SS_E  = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   V_SE_E  = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [COLOR_BITS-1:0] ONES = '1;

  logic [HW-1:0]         r_h;
  logic [VW-1:0]         r_v;
  logic [7:0]            r_frame;
  logic [1:0]            r_mode;
  logic                  r_hsync, r_vsync, r_hblank, r_vblank;
  logic [COLOR_BITS-1:0] r_r, r_g, r_b;
  logic [7:0]            r_frame_o;
  logic [HW-1:0]         r_hpos;
  logic [VW-1:0]         r_vpos;

  logic [HW:0]           w_hx;
  logic [VW:0]           w_vx;
  logic                  w_hblank, w_vblank, w_hsync_on, w_vsync_on;
  logic                  w_start;
  logic [1:0]            w_mode;
  logic [2:0]            w_bar;
  logic                  w_chk;
  logic [COLOR_BITS-1:0] w_x, w_fgrad;
  logic [COLOR_BITS-1:0] w_r, w_g, w_b;

  assign w_hx       = {1'b0, r_h};
  assign w_vx       = {1'b0, r_v};
  assign w_hblank   = (w_hx >= H_ACT_E);
  assign w_vblank   = (w_vx >= V_ACT_E);
  assign w_hsync_on = (w_hx >= H_SS_E) && (w_hx < H_SE_E);
  assign w_vsync_on = (w_vx >= V_SS_E) && (w_vx < V_SE_E);
  assign w_start    = (r_h == '0) && (r_v == '0);
  // Pixel (0,0) already shows the newly sampled mode.
  assign w_mode     = w_start ? vga.mode : r_mode;

  assign w_x   = COLOR_BITS'(r_h) ^ COLOR_BITS'(r_v);
  assign w_chk = 1'(((6'(r_h) + 6'(r_frame)) ^ 6'(r_v)) >> 5);

  generate
    if (COLOR_BITS <= 8) begin : g_fgrad_hi
      assign w_fgrad = COLOR_BITS'(r_frame >> (8 - COLOR_BITS));
    end else begin : g_fgrad_ext
      assign w_fgrad = COLOR_BITS'(r_frame);
    end
  endgenerate

  // Bar index as a threshold count avoids a divider: bar = (h*8)/H_ACTIVE.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({r_h, 3'b000} >= (HW+3)'(k * H_ACTIVE)) w_bar = 3'(k);
    end
  end

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (w_mode)
      2'd0: begin
        w_r = COLOR_BITS'(r_h);
        w_g = COLOR_BITS'(r_v);
        w_b = w_fgrad;
      end
      2'd1: begin
        w_r = w_bar[2] ? ONES : '0;
        w_g = w_bar[1] ? ONES : '0;
        w_b = w_bar[0] ? ONES : '0;
      end
      2'd2: begin
        w_r = w_chk ? ONES : '0;
        w_g = w_chk ? ONES : '0;
        w_b = w_chk ? ONES : '0;
      end
      default: begin
        w_r = w_x;
        w_g = w_x + COLOR_BITS'(r_frame);
        w_b = COLOR_BITS'(r_v);
      end
    endcase
    if (w_hblank || w_vblank) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h       <= '0;
      r_v       <= '0;
      r_frame   <= '0;
      r_mode    <= '0;
      r_hsync   <= ~SYNC_POL;
      r_vsync   <= ~SYNC_POL;
      r_hblank  <= 1'b0;
      r_vblank  <= 1'b0;
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
      r_frame_o <= '0;
      r_hpos    <= '0;
      r_vpos    <= '0;
    end else if (vga.en) begin
      r_hsync   <= w_hsync_on ? SYNC_POL : ~SYNC_POL;
      r_vsync   <= w_vsync_on ? SYNC_POL : ~SYNC_POL;
      r_hblank  <= w_hblank;
      r_vblank  <= w_vblank;
      r_r       <= w_r;
      r_g       <= w_g;
      r_b       <= w_b;
      r_frame_o <= r_frame;
      r_hpos    <= r_h;
      r_vpos    <= r_v;
      if (w_start) r_mode <= vga.mode;
      if (r_h == H_LAST) begin
        r_h <= '0;
        if (r_v == V_LAST) begin
          r_v     <= '0;
          r_frame <= r_frame + 8'd1;
        end else begin
          r_v <= r_v + 1'b1;
        end
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign vga.hsync  = r_hsync;
  assign vga.vsync  = r_vsync;
  assign vga.hblank = r_hblank;
  assign vga.vblank = r_vblank;
  assign vga.r      = r_r;
  assign vga.g      = r_g;
  assign vga.b      = r_b;
  assign vga.frame  = r_frame_o;
  assign vga.hpos   = r_hpos;
  assign vga.vpos   = r_vpos;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboarded bench: the model derives (h,v,frame) from a count of enabled
// cycles since reset and evaluates the pattern rules with plain arithmetic.
module tb_vga_pattern_gen;
  localparam int HA = 12, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6,  VFP = 1, VS = 1, VBP = 2;
  localparam int CB = 4;
  localparam bit SP = 1'b0;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int FT = HT * VT;

  typedef struct packed {
    logic          hs, vs, hb, vb;
    logic [CB-1:0] r, g, b;
    logic [7:0]    fr;
    logic [HW-1:0] hp;
    logic [VW-1:0] vp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.HW(HW), .VW(VW), .COLOR_BITS(CB)) vif ();

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .COLOR_BITS(CB), .SYNC_POL(SP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vga (vif)
  );

  exp_t expq[$];
  int   checks = 0;
  int   fails  = 0;
  int   mt     = 0;
  int   mmode  = 0;
  logic [1:0] cur_mode = 2'd0;
  exp_t exp_cur;

  function automatic exp_t reset_exp();
    exp_t e;
    e    = '0;
    e.hs = ~SP;
    e.vs = ~SP;
    return e;
  endfunction

  function automatic exp_t pix(int h, int v, int f, int m);
    exp_t e;
    int n1, bar, c, x;
    n1   = 1 << CB;
    e    = '0;
    e.hs = (h >= HA + HFP && h < HA + HFP + HS) ? SP : ~SP;
    e.vs = (v >= VA + VFP && v < VA + VFP + VS) ? SP : ~SP;
    e.hb = (h >= HA);
    e.vb = (v >= VA);
    e.fr = 8'(f);
    e.hp = HW'(h);
    e.vp = VW'(v);
    if (h < HA && v < VA) begin
      case (m)
        0: begin
          e.r = CB'(h % n1);
          e.g = CB'(v % n1);
          e.b = (CB <= 8) ? CB'(f / (1 << (8 - CB))) : CB'(f);
        end
        1: begin
          bar = (h * 8) / HA;
          e.r = ((bar / 4) % 2 == 1) ? CB'(n1 - 1) : '0;
          e.g = ((bar / 2) % 2 == 1) ? CB'(n1 - 1) : '0;
          e.b = (bar % 2 == 1)       ? CB'(n1 - 1) : '0;
        end
        2: begin
          c   = (((h + f) ^ v) / 32) % 2;
          e.r = (c == 1) ? CB'(n1 - 1) : '0;
          e.g = e.r;
          e.b = e.r;
        end
        default: begin
          x   = h ^ v;
          e.r = CB'(x % n1);
          e.g = CB'((x + f) % n1);
          e.b = CB'(v % n1);
        end
      endcase
    end
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must show after the edge.
  task automatic step(input logic rst_v, input logic en_v, input logic [1:0] mode_v);
    int h, v, f, um;
    rst      = rst_v;
    vif.en   = en_v;
    vif.mode = mode_v;
    if (rst_v) begin
      mt      = 0;
      mmode   = 0;
      exp_cur = reset_exp();
    end else if (en_v) begin
      h  = mt % HT;
      v  = (mt / HT) % VT;
      f  = (mt / FT) % 256;
      um = (mt % FT == 0) ? int'(mode_v) : mmode;
      if (mt % FT == 0) mmode = int'(mode_v);
      exp_cur = pix(h, v, f, um);
      mt++;
    end
    expq.push_back(exp_cur);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, m);
  endtask

  task automatic run_to(input int hh, input int vv, input logic [1:0] m);
    for (int i = 0; i < 4 * FT; i++) begin
      if (mt % HT == hh && (mt / HT) % VT == vv) break;
      step(1'b0, 1'b1, m);
    end
  endtask

  initial begin : monitor
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        got.hs = vif.hsync;  got.vs = vif.vsync;
        got.hb = vif.hblank; got.vb = vif.vblank;
        got.r  = vif.r;      got.g  = vif.g;      got.b = vif.b;
        got.fr = vif.frame;  got.hp = vif.hpos;   got.vp = vif.vpos;
        if (fails < 40) begin
          checks++;
          if (got !== e) begin
            fails++;
            $display("FAIL out@%0t got hs=%b vs=%b hb=%b vb=%b rgb=%h/%h/%h fr=%0d pos=%0d,%0d want hs=%b vs=%b hb=%b vb=%b rgb=%h/%h/%h fr=%0d pos=%0d,%0d",
                     $time, got.hs, got.vs, got.hb, got.vb, got.r, got.g, got.b, got.fr, got.hp, got.vp,
                     e.hs, e.vs, e.hb, e.vb, e.r, e.g, e.b, e.fr, e.hp, e.vp);
          end
        end
      end
    end
  end

  initial begin : stim
    vif.en   = 1'b1;
    vif.mode = 2'd0;
    repeat (3) step(1'b1, 1'b1, 2'd1);
    run(2 * FT, 2'd1);
    // Bars requested, then checker asked for mid-frame: bars must hold to frame end.
    run_to(5, 3, 2'd1);
    run(2 * FT, 2'd2);
    run_to(7, 2, 2'd2);
    repeat (50) step(1'b0, 1'b0, 2'd3);
    run(FT, 2'd0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) cur_mode = 2'($urandom_range(0, 3));
      step(1'b0, ($urandom_range(0, 9) != 0), cur_mode);
    end
    run_to(8, 4, 2'd3);
    step(1'b1, 1'b1, 2'd3);
    run(FT + 37, 2'd3);
    // Full frame-counter wrap with the mode rotating each frame.
    for (int fr = 0; fr < 257; fr++) run(FT, 2'(fr % 4));
    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain got %0d queued want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
